// File: rtl/unshift_stream_if.sv
// Byte-stream bundle for unshift_stream: shifted beats in, realigned words out.
// state_o reports the realignment FSM state (0 = PRIME, 1 = STREAM).
interface unshift_stream_if #(
    parameter int DATA_BUS_WIDTH = 4
);
    logic                          tvalid_i;
    logic                          tready_o;
    logic [8*DATA_BUS_WIDTH-1:0]   tdata_i;
    logic                          tlast_i;
    logic                          tvalid_o;
    logic                          tready_i;
    logic [8*DATA_BUS_WIDTH-1:0]   tdata_o;
    logic                          tlast_o;
    logic                          err_o;
    logic                          state_o;

    // Handshake: a beat moves on a rising edge where valid & ready are both high;
    // a source holds valid/data/last stable until accepted, ready may change freely.
    modport slave (
        input  tvalid_i, tdata_i, tlast_i, tready_i,
        output tready_o, tvalid_o, tdata_o, tlast_o, err_o, state_o
    );

    modport master (
        output tvalid_i, tdata_i, tlast_i, tready_i,
        input  tready_o, tvalid_o, tdata_o, tlast_o, err_o, state_o
    );
endinterface

// File: rtl/unshift_stream.sv
// Undoes a SHIFT_BYTES lane shift: each pair of consecutive shifted beats is
// recombined into one original-aligned word held in a registered output slice.
module unshift_stream #(
    parameter int DATA_BUS_WIDTH = 4,
    parameter int SHIFT_BYTES    = 2
) (
    input  logic             clk_i,
    input  logic             areset_ni,
    unshift_stream_if.slave  s
);
    localparam int W  = DATA_BUS_WIDTH;
    localparam int S  = SHIFT_BYTES;
    localparam int DW = 8 * W;

    if (S < 1 || S > W - 1) begin : g_bad_shift
        $error("unshift_stream: SHIFT_BYTES must lie in 1..DATA_BUS_WIDTH-1");
    end
    if ($bits(s.tdata_i) != DW) begin : g_bad_width
        $error("unshift_stream: interface width does not match DATA_BUS_WIDTH");
    end

    typedef enum logic {
        PRIME  = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   hold_q;
    logic [DW-1:0]   data_q;
    logic            valid_q;
    logic            last_q;
    logic            err_q;

    logic            accept;
    logic            load_word;
    logic            load_hold;
    logic            drop;
    logic [DW-1:0]   word;

    assign s.tready_o = ~valid_q | s.tready_i;
    assign accept     = s.tvalid_i & s.tready_o;

    // Upper lanes of the held beat become the low lanes of the word.
    assign word = {s.tdata_i[8*S-1:0], hold_q[DW-1:8*S]};

    always_comb begin
        state_d   = state_q;
        load_word = 1'b0;
        load_hold = 1'b0;
        drop      = 1'b0;
        case (state_q)
            PRIME: begin
                if (accept) begin
                    if (s.tlast_i) begin
                        drop = 1'b1;
                    end else begin
                        load_hold = 1'b1;
                        state_d   = STREAM;
                    end
                end
            end
            STREAM: begin
                if (accept) begin
                    load_word = 1'b1;
                    load_hold = 1'b1;
                    if (s.tlast_i) begin
                        state_d = PRIME;
                    end
                end
            end
            default: state_d = PRIME;
        endcase
    end

    always_ff @(posedge clk_i or negedge areset_ni) begin
        if (!areset_ni) begin
            state_q <= PRIME;
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= drop;
            if (load_hold) begin
                hold_q <= s.tdata_i;
            end
            // A new word overrides a drain in the same cycle, keeping valid high.
            if (load_word) begin
                data_q  <= word;
                last_q  <= s.tlast_i;
                valid_q <= 1'b1;
            end else if (s.tready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign s.tvalid_o = valid_q;
    assign s.tdata_o  = data_q;
    assign s.tlast_o  = last_q;
    assign s.err_o    = err_q;
    assign s.state_o  = state_q;
endmodule

// File: tb/tb_unshift_stream.sv
// Bench for unshift_stream: packets of original words are shifted into beats by a
// reference model, and the realigned output is checked against the original words.
module tb_unshift_stream;
    localparam int W  = 4;
    localparam int S  = 2;
    localparam int DW = 8 * W;

    logic clk;
    logic rst_n;

    unshift_stream_if #(.DATA_BUS_WIDTH(W)) bus ();

    unshift_stream #(.DATA_BUS_WIDTH(W), .SHIFT_BYTES(S)) dut (
        .clk_i     (clk),
        .areset_ni (rst_n),
        .s         (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- downstream ready control ----------------
    // 0: always ready, 1: random, 2: opposite phase of tvalid_i, 3: forced_ready
    int   rdy_mode;
    logic forced_ready;
    logic rnd_ready;

    initial rnd_ready = 1'b1;
    always @(posedge clk) begin
        #2;
        rnd_ready = (rdy_mode == 1) ? 1'($urandom_range(1, 0)) : 1'b1;
    end

    assign bus.tready_i = (rdy_mode == 3) ? forced_ready :
                          (rdy_mode == 2) ? ~bus.tvalid_i : rnd_ready;

    // ---------------- scoreboard ----------------
    logic [DW:0] exp_q[$];
    logic [DW:0] got_q[$];
    int          err_seen;
    int          checks;
    int          errors;

    initial err_seen = 0;
    always @(negedge clk) begin
        if (rst_n && bus.tvalid_o && bus.tready_i) got_q.push_back({bus.tlast_o, bus.tdata_o});
        if (rst_n && bus.err_o) err_seen++;
    end

    // ---------------- drivers ----------------
    task automatic send_beat(input logic [DW-1:0] d, input logic l, input int min_gap,
                             input int max_gap);
        logic acc;
        bit   ok;
        ok = 0;
        bus.tvalid_i = 1'b1;
        bus.tdata_i  = d;
        bus.tlast_i  = l;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            acc = bus.tready_o;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1;
                break;
            end
        end
        bus.tvalid_i = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout data %h not accepted within 300 cycles", d);
        end
        repeat ($urandom_range(max_gap, min_gap)) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model of the shifting stage: N words become N+1 beats, don't-care lanes random.
    task automatic send_packet(input int n, input int min_gap, input int max_gap,
                               input bit inc_data, input logic [DW-1:0] start);
        logic [DW-1:0] words[$];
        logic [DW-1:0] w;
        logic [DW-1:0] prev;
        logic [DW-1:0] beat;
        for (int i = 0; i < n; i++) begin
            w = inc_data ? start + DW'(i) : $urandom;
            words.push_back(w);
            exp_q.push_back({(i == n - 1), w});
        end
        for (int k = 0; k <= n; k++) begin
            beat = $urandom;
            w    = (k < n) ? words[k] : '0;
            prev = (k > 0) ? words[k-1] : '0;
            for (int j = 0; j < W; j++) begin
                if (j >= S && k < n) beat[8*j +: 8] = w[8*(j-S) +: 8];
                else if (j < S && k > 0) beat[8*j +: 8] = prev[8*(W-S+j) +: 8];
            end
            send_beat(beat, (k == n), min_gap, max_gap);
        end
    endtask

    task automatic wait_drain(input int gb, input int eb);
        for (int c = 0; c < 2000 && (got_q.size() - gb) < (exp_q.size() - eb); c++) begin
            @(posedge clk);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n        = 1'b0;
        rdy_mode     = 0;
        forced_ready = 1'b0;
        bus.tvalid_i = 1'b0;
        bus.tdata_i  = '0;
        bus.tlast_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.tvalid_o !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", bus.tvalid_o); end
        checks++; if (bus.tdata_o !== '0) begin errors++; $display("FAIL reset_tdata got %h exp 0", bus.tdata_o); end
        checks++; if (bus.tlast_o !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b exp 0", bus.tlast_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err_o); end
        checks++; if (bus.tready_o !== 1'b1) begin errors++; $display("FAIL reset_tready got %b exp 1", bus.tready_o); end
        checks++; if (bus.state_o !== 1'b0) begin errors++; $display("FAIL reset_state got %b exp 0", bus.state_o); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.tready_o !== 1'b1) begin errors++; $display("FAIL post_reset_tready got %b exp 1", bus.tready_o); end
    endtask

    task automatic test_basic();
        int gb;
        gb = got_q.size();
        rdy_mode = 0;
        send_beat(32'h22110000, 1'b0, 0, 0);
        checks++; if (bus.tvalid_o !== 1'b0) begin errors++; $display("FAIL basic_prime_valid got %b exp 0", bus.tvalid_o); end
        send_beat(32'h66554433, 1'b0, 0, 0);
        checks++; if ({bus.tvalid_o, bus.tlast_o, bus.tdata_o} !== {2'b10, 32'h44332211}) begin
            errors++; $display("FAIL basic_word0 got v%b l%b %h exp v1 l0 44332211", bus.tvalid_o, bus.tlast_o, bus.tdata_o); end
        send_beat(32'h00008877, 1'b1, 0, 0);
        checks++; if ({bus.tvalid_o, bus.tlast_o, bus.tdata_o} !== {2'b11, 32'h88776655}) begin
            errors++; $display("FAIL basic_word1 got v%b l%b %h exp v1 l1 88776655", bus.tvalid_o, bus.tlast_o, bus.tdata_o); end
        @(posedge clk);
        #1;
        checks++; if (bus.tvalid_o !== 1'b0) begin errors++; $display("FAIL basic_idle_valid got %b exp 0", bus.tvalid_o); end
        checks++; if (got_q.size() - gb !== 2) begin errors++; $display("FAIL basic_count got %0d exp 2", got_q.size() - gb); end
    endtask

    task automatic test_backpressure();
        int gb;
        gb = got_q.size();
        rdy_mode     = 3;
        forced_ready = 1'b0;
        send_beat(32'h22110000, 1'b0, 0, 0);
        send_beat(32'h66554433, 1'b0, 0, 0);
        bus.tvalid_i = 1'b1;
        bus.tdata_i  = 32'h00008877;
        bus.tlast_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({bus.tready_o, bus.tvalid_o, bus.tdata_o} !== {2'b01, 32'h44332211}) begin
                errors++; $display("FAIL bp_hold got rdy%b v%b %h exp rdy0 v1 44332211", bus.tready_o, bus.tvalid_o, bus.tdata_o); end
            @(posedge clk);
            #1;
        end
        forced_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.tready_o !== 1'b1) begin errors++; $display("FAIL bp_release_tready got %b exp 1", bus.tready_o); end
        @(posedge clk);
        #1;
        bus.tvalid_i = 1'b0;
        checks++; if ({bus.tvalid_o, bus.tlast_o, bus.tdata_o} !== {2'b11, 32'h88776655}) begin
            errors++; $display("FAIL bp_drain_load got v%b l%b %h exp v1 l1 88776655", bus.tvalid_o, bus.tlast_o, bus.tdata_o); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (got_q.size() - gb !== 2) begin errors++; $display("FAIL bp_count got %0d exp 2", got_q.size() - gb); end
        else begin
            checks++; if (got_q[gb] !== {1'b0, 32'h44332211}) begin errors++; $display("FAIL bp_out0 got %h exp 044332211", got_q[gb]); end
            checks++; if (got_q[gb+1] !== {1'b1, 32'h88776655}) begin errors++; $display("FAIL bp_out1 got %h exp 188776655", got_q[gb+1]); end
        end
        rdy_mode = 0;
    endtask

    task automatic test_alternate();
        int gb, eb;
        gb = got_q.size();
        eb = exp_q.size();
        rdy_mode = 2;
        send_packet(100, 1, 1, 1'b1, 32'h0000_0100);
        wait_drain(gb, eb);
        rdy_mode = 0;
        checks++; if (got_q.size() - gb !== exp_q.size() - eb) begin
            errors++; $display("FAIL alt_count got %0d exp %0d", got_q.size() - gb, exp_q.size() - eb); end
        for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
            checks++; if (got_q[gb+i] !== exp_q[eb+i]) begin
                errors++; $display("FAIL alt_word%0d got %h exp %h", i, got_q[gb+i], exp_q[eb+i]); end
        end
    endtask

    task automatic test_single_beat();
        int gb, eb, e0;
        gb = got_q.size();
        eb = exp_q.size();
        e0 = err_seen;
        rdy_mode = 0;
        send_beat(32'hDEADBEEF, 1'b1, 0, 0);
        checks++; if ({bus.err_o, bus.tvalid_o, bus.state_o} !== 3'b100) begin
            errors++; $display("FAIL single_err got err%b v%b st%b exp err1 v0 st0", bus.err_o, bus.tvalid_o, bus.state_o); end
        @(posedge clk);
        #1;
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL single_err_width got %b exp 0", bus.err_o); end
        send_packet(3, 0, 0, 1'b0, '0);
        wait_drain(gb, eb);
        checks++; if (err_seen - e0 !== 1) begin errors++; $display("FAIL single_err_count got %0d exp 1", err_seen - e0); end
        checks++; if (got_q.size() - gb !== 3) begin errors++; $display("FAIL single_next_count got %0d exp 3", got_q.size() - gb); end
        for (int i = 0; i < 3 && i < got_q.size() - gb; i++) begin
            checks++; if (got_q[gb+i] !== exp_q[eb+i]) begin
                errors++; $display("FAIL single_next_word%0d got %h exp %h", i, got_q[gb+i], exp_q[eb+i]); end
        end
    endtask

    task automatic test_reset_mid();
        int gb, eb;
        rdy_mode     = 3;
        forced_ready = 1'b0;
        send_beat(32'h33221100, 1'b0, 0, 0);
        send_beat(32'h77665544, 1'b0, 0, 0);
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.tvalid_o, bus.tlast_o, bus.err_o, bus.tdata_o} !== {3'b000, 32'h0}) begin
            errors++; $display("FAIL midreset_outputs got v%b l%b e%b %h exp all 0", bus.tvalid_o, bus.tlast_o, bus.err_o, bus.tdata_o); end
        checks++; if ({bus.tready_o, bus.state_o} !== 2'b10) begin
            errors++; $display("FAIL midreset_ready_state got rdy%b st%b exp rdy1 st0", bus.tready_o, bus.state_o); end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        gb = got_q.size();
        eb = exp_q.size();
        send_packet(2, 0, 0, 1'b0, '0);
        wait_drain(gb, eb);
        checks++; if (got_q.size() - gb !== 2) begin errors++; $display("FAIL midreset_count got %0d exp 2", got_q.size() - gb); end
        for (int i = 0; i < 2 && i < got_q.size() - gb; i++) begin
            checks++; if (got_q[gb+i] !== exp_q[eb+i]) begin
                errors++; $display("FAIL midreset_word%0d got %h exp %h", i, got_q[gb+i], exp_q[eb+i]); end
        end
    endtask

    task automatic test_back_to_back();
        int gb, eb;
        gb = got_q.size();
        eb = exp_q.size();
        rdy_mode = 1;
        for (int p = 0; p < 8; p++) begin
            send_packet($urandom_range(8, 1), 0, (p < 4) ? 0 : 2, 1'b0, '0);
        end
        wait_drain(gb, eb);
        rdy_mode = 0;
        checks++; if (got_q.size() - gb !== exp_q.size() - eb) begin
            errors++; $display("FAIL b2b_count got %0d exp %0d", got_q.size() - gb, exp_q.size() - eb); end
        for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
            checks++; if (got_q[gb+i] !== exp_q[eb+i]) begin
                errors++; $display("FAIL b2b_word%0d got %h exp %h", i, got_q[gb+i], exp_q[eb+i]); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_alternate();
        test_single_beat();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/unshift_stream.md
# unshift_stream

Byte-realignment stage that undoes the `shift_stream` lane shift on a valid/ready byte stream. It recombines each pair of consecutive shifted beats into one original-aligned word. It sits at the receive end of any path that `shift_stream` fed, and its output is bit-identical to the word stream that entered `shift_stream`. It has a one-beat holding register and a registered output slice with full-throughput backpressure.

## Interface
- `DATA_BUS_WIDTH`, default 4: bytes per beat (W); data width is 8*W.
- `SHIFT_BYTES`, default 2: byte shift to remove (S). Legal range is 1..W-1; any other value is an elaboration error.
- `clk_i`, in, 1: the single clock; all logic is on its rising edge.
- `areset_ni`, in, 1: reset, asynchronous and active-low.
- `tvalid_i`, in, 1: input beat valid.
- `tready_o`, out, 1: input beat accepted when `tvalid_i & tready_o`.
- `tdata_i`, in, 8*W: shifted input beat; byte lane j is bits [8j+7:8j].
- `tlast_i`, in, 1: marks the flush beat, which is the last beat of a shifted packet.
- `tvalid_o`, out, 1: output word valid.
- `tready_i`, in, 1: downstream ready.
- `tdata_o`, out, 8*W: realigned word.
- `tlast_o`, out, 1: last word of a packet.
- `err_o`, out, 1: one-cycle pulse when a single-beat packet (tlast on the priming beat) is dropped.

## Operation
- Input format for a packet of N original words is N+1 shifted beats:
  - Beat k carries original word k's lanes 0..W-S-1 in lanes S..W-1.
  - Beat k carries original word k-1's lanes W-S..W-1 in lanes 0..S-1.
  - Beat N is the flush beat and has `tlast_i`=1.
- State machine:
  - PRIME: an accepted beat loads the holding register `hold`, produces no output, and moves to STREAM.
    - Exception: if that beat has `tlast_i`=1, it is discarded, `err_o` pulses and the state stays PRIME.
  - STREAM: an accepted beat builds an output word:
    - output lanes 0..W-S-1 = `hold` lanes S..W-1;
    - output lanes W-S..W-1 = current `tdata_i` lanes 0..S-1.
    - The word loads into the output register with `tlast_o` = `tlast_i`.
    - `hold` takes the current beat.
    - If `tlast_i`=1, the state returns to PRIME; otherwise it stays in STREAM.
- Lanes 0..S-1 of the priming beat and lanes S..W-1 of the flush beat are ignored.
- `tready_o` = ~`tvalid_o` | `tready_i`. This is combinational from `tready_i` and applies in both states.

## Timing
- Reset (asynchronous, from `areset_ni` low):
  - `tvalid_o`=0, `tdata_o`=0, `tlast_o`=0, `err_o`=0.
  - `hold`=0, state = PRIME.
  - `tready_o` is therefore 1 during and after reset.
  - Reset asserted mid-packet abandons the packet with no partial output; the first beat after release is a priming beat.
- Latency: the output word is valid on the cycle after the accepted input beat that completes it.
- Throughput: one beat per cycle in STREAM when `tready_i` is held high. Each packet costs one extra input beat (N+1 in, N out).
- Output hold: while `tvalid_o` & ~`tready_i`, `tdata_o` and `tlast_o` stay stable and `tready_o`=0.
- Simultaneous drain and load: in a cycle where the output is accepted and a new STREAM beat is accepted, the register takes the new word and `tvalid_o` stays 1.
  - Output accepted with no new word: `tvalid_o` clears.
  - An accepted priming beat never sets `tvalid_o`.
- Back-to-back packets: after a flush beat, the next accepted beat is the priming beat of the next packet, with no idle cycle required.
- `err_o` is high for exactly the cycle after the dropped beat is accepted.

## Test plan
All cases use W=4, S=2.
- **Basic packet.** Input 0x22110000, then 0x66554433, then 0x00008877 with `tlast_i`=1, and `tready_i`=1 throughout.
  - Required: 0x44332211 with `tlast_o`=0, then 0x88776655 with `tlast_o`=1.
  - Each word appears one cycle after its completing input.
  - 2 outputs for 3 inputs.
- **Backpressure.** Same stream with `tready_i`=0 while the first output is pending.
  - Required: `tready_o`=0 and `tdata_o` holds 0x44332211 until `tready_i`=1.
  - No beat is lost or duplicated.
- **Alternating handshake.** `tvalid_i` and `tready_i` toggle in opposite phases every cycle over 100 words with incrementing data.
  - Required: the output sequence is the exact original words in order.
- **Single-beat packet.** Priming beat with `tlast_i`=1.
  - Required: `err_o` pulses for 1 cycle, no output, and the next packet realigns correctly.
- **Reset mid-packet.** Pull `areset_ni` low after the priming beat and one STREAM beat, with the output stalled.
  - Required: all outputs are 0 immediately.
  - After release, a new 3-beat packet yields exactly its 2 words.
